lif_synapse_accumulator: RTL and testbench



---
 rtl/lif_pkg.sv | 21 ++
 rtl/lif_sat_clip.sv | 31 +++
 rtl/lif_synapse_accumulator.sv | 142 ++++++++++++++
 tb/tb_lif_synapse_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron pipeline: default sizing and FSM state codes.
package lif_pkg;

    // Default sizing, reused by the synapse accumulator and the neuron core.
    localparam int unsigned DefNSyn = 8;
    localparam int unsigned DefWW   = 8;
    localparam int unsigned DefOutW = 8;

    // Transaction FSM states.
    typedef logic [1:0] lif_state_t;

    localparam lif_state_t StIdle   = 2'd0;
    localparam lif_state_t StAccum  = 2'd1;
    localparam lif_state_t StOutput = 2'd2;

    // Accumulator width that can hold the sum of n_syn signed w_w-bit weights.
    function automatic int unsigned acc_width(input int unsigned n_syn, input int unsigned w_w);
        return w_w + $clog2(n_syn);
    endfunction

endpackage

// File: rtl/lif_sat_clip.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits.
module lif_sat_clip #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned OUT_W = 8
) (
    input  logic [IN_W-1:0]  val_i,
    output logic [OUT_W-1:0] val_o,
    output logic             sat_o
);

    localparam int unsigned TopW = IN_W - OUT_W + 1;

    logic [TopW-1:0]  top_bits;
    logic [OUT_W-1:0] pos_lim;
    logic [OUT_W-1:0] neg_lim;

    assign top_bits = val_i[IN_W-1:OUT_W-1];
    assign pos_lim  = {1'b0, {(OUT_W - 1){1'b1}}};
    assign neg_lim  = {1'b1, {(OUT_W - 1){1'b0}}};

    // The value fits iff every bit above the output sign bit replicates it.
    always_comb begin
        sat_o = !((&top_bits) || !(|top_bits));
        if (sat_o) begin
            val_o = val_i[IN_W-1] ? neg_lim : pos_lim;
        end else begin
            val_o = val_i[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/lif_synapse_accumulator.sv
// Serial synapse accumulator: sums the weights of fired synapses, one per cycle,
// and hands a saturated current to the neuron over a valid/ready handshake.
module lif_synapse_accumulator
    import lif_pkg::*;
#(
    parameter int unsigned N_SYN = DefNSyn,
    parameter int unsigned W_W   = DefWW,
    parameter int unsigned OUT_W = DefOutW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spk_valid,
    output logic                     spk_ready,
    input  logic [N_SYN-1:0]         spk_vec,
    input  logic                     w_we,
    input  logic [$clog2(N_SYN)-1:0] w_addr,
    input  logic [W_W-1:0]           w_data,
    output logic                     cur_valid,
    input  logic                     cur_ready,
    output logic [OUT_W-1:0]         cur_data,
    output logic                     cur_sat,
    output logic                     busy
);

    localparam int unsigned IdxW = $clog2(N_SYN);
    localparam int unsigned AccW = acc_width(N_SYN, W_W);

    lif_state_t             state_q, state_d;
    logic [N_SYN-1:0]       spk_vec_q, spk_vec_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [W_W-1:0]         w_q [N_SYN];
    logic [OUT_W-1:0]       cur_data_q, cur_data_d;
    logic                   cur_sat_q, cur_sat_d;

    logic [W_W-1:0]         w_sel;
    logic signed [AccW-1:0] w_ext;
    logic                   last_idx;
    logic [OUT_W-1:0]       clip_data;
    logic                   clip_sat;

    assign w_sel    = w_q[idx_q];
    assign w_ext    = {{IdxW{w_sel[W_W-1]}}, w_sel};
    assign last_idx = (idx_q == IdxW'(N_SYN - 1));

    // Clip the value the accumulator is about to hold, so the result register
    // captures it on the same edge that finishes the last synapse.
    lif_sat_clip #(
        .IN_W  (AccW),
        .OUT_W (OUT_W)
    ) u_sat_clip (
        .val_i (acc_d),
        .val_o (clip_data),
        .sat_o (clip_sat)
    );

    // Next-state for the transaction FSM and the serial accumulation datapath.
    always_comb begin
        state_d   = state_q;
        spk_vec_d = spk_vec_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        unique case (state_q)
            StIdle: begin
                if (spk_valid) begin
                    spk_vec_d = spk_vec;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                // Fixed latency: every synapse takes a cycle whether it fired or not.
                if (spk_vec_q[idx_q]) begin
                    acc_d = acc_q + w_ext;
                end
                idx_d = idx_q + IdxW'(1);
                if (last_idx) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (cur_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Result capture: loaded only when accumulation completes, held through OUTPUT.
    always_comb begin
        cur_data_d = cur_data_q;
        cur_sat_d  = cur_sat_q;
        if (state_q == StAccum && last_idx) begin
            cur_data_d = clip_data;
            cur_sat_d  = clip_sat;
        end
    end

    // Transaction state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            spk_vec_q  <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            cur_data_q <= '0;
            cur_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            spk_vec_q  <= spk_vec_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            cur_data_q <= cur_data_d;
            cur_sat_q  <= cur_sat_d;
        end
    end

    // Weight register file; writes are locked out while a vector is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_SYN); i++) begin
                w_q[i] <= '0;
            end
        end else if (w_we && state_q == StIdle) begin
            w_q[w_addr] <= w_data;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        spk_ready = (state_q == StIdle);
        cur_valid = (state_q == StOutput);
        busy      = (state_q != StIdle);
        cur_data  = cur_data_q;
        cur_sat   = cur_sat_q;
    end

endmodule

// File: tb/tb_lif_synapse_accumulator.sv
// Self-checking bench for lif_synapse_accumulator (N_SYN=8, W_W=8, OUT_W=8).
module tb_lif_synapse_accumulator;

    logic       clk;
    logic       rst_n;
    logic       spk_valid;
    logic       spk_ready;
    logic [7:0] spk_vec;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       cur_valid;
    logic       cur_ready;
    logic [7:0] cur_data;
    logic       cur_sat;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference weights as plain signed integers.
    int model_w [8];

    lif_synapse_accumulator #(
        .N_SYN (8),
        .W_W   (8),
        .OUT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_vec   (spk_vec),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .cur_valid (cur_valid),
        .cur_ready (cur_ready),
        .cur_data  (cur_data),
        .cur_sat   (cur_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v,
                   exp_v);
        end
    endtask

    function automatic int ref_sum(input logic [7:0] vec);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) s += model_w[i];
        end
        return s;
    endfunction

    function automatic logic [7:0] ref_clip(input int s);
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    function automatic logic ref_sat(input int s);
        return (s > 127) || (s < -128);
    endfunction

    task automatic write_w(input int a, input int v);
        w_we   = 1'b1;
        w_addr = a[2:0];
        w_data = v[7:0];
        tick();
        w_we   = 1'b0;
        model_w[a] = v;
    endtask

    // Accept a vector (optionally with a same-cycle weight write), wait for the
    // result while poking ignored writes, check it, then consume it.
    task automatic run_vec(input string tag, input logic [7:0] vec, input bit do_w,
                           input int wa, input int wv);
        int         lat;
        int         s;
        logic [7:0] exp_d;
        logic       exp_s;
        if (do_w) model_w[wa] = wv;
        s     = ref_sum(vec);
        exp_d = ref_clip(s);
        exp_s = ref_sat(s);
        check({tag, "_spk_ready_idle"}, {31'b0, spk_ready}, 32'd1);
        spk_valid = 1'b1;
        spk_vec   = vec;
        w_we      = do_w;
        w_addr    = wa[2:0];
        w_data    = wv[7:0];
        tick();
        spk_valid = 1'b0;
        spk_vec   = 8'($urandom);
        lat = 0;
        while (cur_valid !== 1'b1 && lat < 40) begin
            w_we   = 1'($urandom);
            w_addr = 3'($urandom);
            w_data = 8'($urandom);
            tick();
            lat++;
        end
        w_we = 1'b0;
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_data"}, {24'b0, cur_data}, {24'b0, exp_d});
        check({tag, "_sat"}, {31'b0, cur_sat}, {31'b0, exp_s});
        cur_ready = 1'b1;
        tick();
        cur_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, cur_valid}, 32'd0);
        check({tag, "_spk_ready_back"}, {31'b0, spk_ready}, 32'd1);
    endtask

    initial begin
        int         lat;
        logic [7:0] held;
        for (int i = 0; i < 8; i++) model_w[i] = 0;
        rst_n     = 1'b0;
        spk_valid = 1'b0;
        spk_vec   = 8'h00;
        w_we      = 1'b0;
        w_addr    = 3'd0;
        w_data    = 8'h00;
        cur_ready = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_spk_ready", {31'b0, spk_ready}, 32'd1);
        check("rst_cur_valid", {31'b0, cur_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cur_data", {24'b0, cur_data}, 32'd0);
        check("rst_cur_sat", {31'b0, cur_sat}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Default weights are all zero.
        run_vec("t1_ff_zero_w", 8'hFF, 1'b0, 0, 0);

        // Small positive sums, then a single negative weight.
        for (int i = 0; i < 8; i++) write_w(i, i + 1);
        run_vec("t2_vec05", 8'h05, 1'b0, 0, 0);
        check("t2_vec05_const", {24'b0, cur_data}, 32'd4);
        write_w(7, -3);
        run_vec("t2_vec80", 8'h80, 1'b0, 0, 0);

        // Positive and negative saturation.
        for (int i = 0; i < 8; i++) write_w(i, 100);
        run_vec("t3_pos_sat", 8'hFF, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) write_w(i, -100);
        run_vec("t3_neg_sat", 8'hFF, 1'b0, 0, 0);
        run_vec("t3_all_zero_vec", 8'h00, 1'b0, 0, 0);

        // Backpressure in OUTPUT: result held, writes ignored.
        write_w(0, 10);
        spk_valid = 1'b1;
        spk_vec   = 8'h01;
        tick();
        spk_valid = 1'b0;
        lat = 0;
        while (cur_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("t4_latency", lat, 32'd8);
        held = cur_data;
        check("t4_data", {24'b0, held}, 32'd10);
        for (int c = 0; c < 5; c++) begin
            w_we   = (c == 2);
            w_addr = 3'd0;
            w_data = 8'd77;
            tick();
            w_we = 1'b0;
            check("t4_hold_data", {24'b0, cur_data}, {24'b0, held});
            check("t4_hold_valid", {31'b0, cur_valid}, 32'd1);
            check("t4_hold_spk_ready", {31'b0, spk_ready}, 32'd0);
        end
        cur_ready = 1'b1;
        tick();
        cur_ready = 1'b0;
        check("t4_release_valid", {31'b0, cur_valid}, 32'd0);
        check("t4_release_busy", {31'b0, busy}, 32'd0);
        run_vec("t4_old_weight", 8'h01, 1'b0, 0, 0);

        // Write and accept in the same IDLE cycle.
        run_vec("t6_same_cycle_w", 8'h04, 1'b1, 2, 50);
        check("t6_const", {24'b0, cur_data}, 32'd50);

        // Randomized vectors and weights against the reference sums.
        for (int it = 0; it < 24; it++) begin
            int nw;
            nw = $urandom_range(3);
            for (int k = 0; k < nw; k++) begin
                write_w($urandom_range(7), $urandom_range(255) - 128);
            end
            run_vec("rnd", 8'($urandom), 1'($urandom), $urandom_range(7),
                    $urandom_range(255) - 128);
        end

        // Asynchronous reset in the 4th ACCUM cycle aborts and clears weights.
        write_w(1, 20);
        spk_valid = 1'b1;
        spk_vec   = 8'h02;
        tick();
        spk_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t5_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'b0, cur_valid}, 32'd0);
        check("t5_async_spk_ready", {31'b0, spk_ready}, 32'd1);
        check("t5_async_busy", {31'b0, busy}, 32'd0);
        check("t5_async_data", {24'b0, cur_data}, 32'd0);
        for (int i = 0; i < 8; i++) model_w[i] = 0;
        tick();
        rst_n = 1'b1;
        tick();
        run_vec("t5_after_rst", 8'h02, 1'b0, 0, 0);
        run_vec("t5_after_rst_ff", 8'hFF, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
